// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative write-back cache.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_REFILL,
    S_RESP
  } state_e;

  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return clog2_u(sets);
  endfunction

  function automatic int unsigned way_w(input int unsigned ways);
    return clog2_u(ways);
  endfunction

endpackage

// File: rtl/cache_assoc_if.sv
// Request/response and backing-memory signals of cache_assoc.
// master = request driver plus backing memory; slave = the cache.
interface cache_assoc_if #(
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned DATA_W = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [IDX_W-1:0]        req_index;
  logic [TAG_W-1:0]        req_tag;
  logic [DATA_W-1:0]       req_wdata;
  logic                    resp_valid;
  logic                    resp_hit;
  logic [DATA_W-1:0]       resp_rdata;
  logic                    mem_valid;
  logic                    mem_write;
  logic [TAG_W+IDX_W-1:0]  mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    mem_ready;
  logic [DATA_W-1:0]       mem_rdata;

  modport master (
    output req_valid, req_write, req_index, req_tag, req_wdata, mem_ready, mem_rdata,
    input  req_ready, resp_valid, resp_hit, resp_rdata,
    input  mem_valid, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_index, req_tag, req_wdata, mem_ready, mem_rdata,
    output req_ready, resp_valid, resp_hit, resp_rdata,
    output mem_valid, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_lru.sv
// True-LRU age bookkeeping for one set: new ages after an access and the LRU way.
module cache_lru import cache_pkg::*; #(
  parameter  int unsigned WAYS = 2,
  localparam int unsigned WW   = way_w(WAYS)
) (
  input  logic [WAYS*WW-1:0] ages_i,
  input  logic [WW-1:0]      access_i,
  output logic [WAYS*WW-1:0] ages_o,
  output logic [WW-1:0]      lru_way_o
);

  logic [WW-1:0] acc_age;
  assign acc_age = ages_i[32'(access_i)*WW +: WW];

  // Kept apart from the age update: the victim choice feeds access_i upstream.
  always_comb begin
    lru_way_o = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (ages_i[w*WW +: WW] == WW'(WAYS - 1)) lru_way_o = WW'(w);
    end
  end

  always_comb begin
    ages_o = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (WW'(w) == access_i) begin
        ages_o[w*WW +: WW] = '0;
      end else if (ages_i[w*WW +: WW] < acc_age) begin
        ages_o[w*WW +: WW] = ages_i[w*WW +: WW] + WW'(1);
      end else begin
        ages_o[w*WW +: WW] = ages_i[w*WW +: WW];
      end
    end
  end

endmodule

// File: rtl/cache_assoc.sv
// N-way set-associative write-back, write-allocate cache with a stalling
// memory port, true-LRU replacement and saturating hit/miss counters.
module cache_assoc import cache_pkg::*; #(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 4,
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  cache_assoc_if.slave bus,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int unsigned IW = idx_w(SETS);
  localparam int unsigned WW = way_w(WAYS);
  localparam int unsigned AW = TAG_W + IW;

  state_e              state_q;
  logic                wr_q;
  logic [IW-1:0]       idx_q;
  logic [TAG_W-1:0]    tag_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [WW-1:0]       victim_q;
  logic                resp_valid_q, resp_hit_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                mem_valid_q, mem_write_q;
  logic [AW-1:0]       mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [15:0]         hit_q, miss_q;

  logic [DATA_W-1:0]   data_q [SETS][WAYS];
  logic [TAG_W-1:0]    tags_q [SETS][WAYS];
  logic [WW-1:0]       age_q  [SETS][WAYS];
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];

  logic                hit, inv_found, vic_dirty;
  logic [WW-1:0]       hit_way, inv_way, lru_way, victim_sel, acc_way;
  logic [WAYS*WW-1:0]  ages_flat, ages_new;
  logic                line_we, line_dirty, age_we;
  logic [DATA_W-1:0]   line_data;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[idx_q][w] && tags_q[idx_q][w] == tag_q) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!inv_found && !valid_q[idx_q][w]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
  end

  always_comb begin
    ages_flat = '0;
    for (int unsigned w = 0; w < WAYS; w++) ages_flat[w*WW +: WW] = age_q[idx_q][w];
  end

  cache_lru #(.WAYS(WAYS)) u_lru (
    .ages_i    (ages_flat),
    .access_i  (acc_way),
    .ages_o    (ages_new),
    .lru_way_o (lru_way)
  );

  assign victim_sel = inv_found ? inv_way : lru_way;
  assign vic_dirty  = valid_q[idx_q][victim_sel] && dirty_q[idx_q][victim_sel];
  // LOOKUP installs/touches the way it just chose; memory phases use the latched victim.
  assign acc_way    = (state_q == S_LOOKUP) ? (hit ? hit_way : victim_sel) : victim_q;

  always_comb begin
    line_we    = 1'b0;
    line_data  = wdata_q;
    line_dirty = 1'b1;
    age_we     = 1'b0;
    case (state_q)
      S_LOOKUP: begin
        if (hit) begin
          line_we = wr_q;
          age_we  = 1'b1;
        end else if (wr_q && !vic_dirty) begin
          line_we = 1'b1;
          age_we  = 1'b1;
        end
      end
      S_WRITEBACK: begin
        if (bus.mem_ready && wr_q) begin
          line_we = 1'b1;
          age_we  = 1'b1;
        end
      end
      S_REFILL: begin
        if (bus.mem_ready) begin
          line_we    = 1'b1;
          age_we     = 1'b1;
          line_data  = bus.mem_rdata;
          line_dirty = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      idx_q        <= '0;
      tag_q        <= '0;
      wdata_q      <= '0;
      victim_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          data_q[s][w] <= '0;
          tags_q[s][w] <= '0;
          age_q[s][w]  <= WW'(w);
        end
      end
    end else begin
      resp_valid_q <= 1'b0;

      if (line_we) begin
        data_q[idx_q][acc_way]  <= line_data;
        tags_q[idx_q][acc_way]  <= tag_q;
        valid_q[idx_q][acc_way] <= 1'b1;
        dirty_q[idx_q][acc_way] <= line_dirty;
      end
      if (age_we) begin
        for (int unsigned w = 0; w < WAYS; w++) age_q[idx_q][w] <= ages_new[w*WW +: WW];
      end

      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            wr_q    <= bus.req_write;
            idx_q   <= bus.req_index;
            tag_q   <= bus.req_tag;
            wdata_q <= bus.req_wdata;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
            resp_hit_q   <= 1'b1;
            resp_rdata_q <= wr_q ? wdata_q : data_q[idx_q][hit_way];
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
            victim_q   <= victim_sel;
            resp_hit_q <= 1'b0;
            if (vic_dirty) begin
              mem_valid_q <= 1'b1;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tags_q[idx_q][victim_sel], idx_q};
              mem_wdata_q <= data_q[idx_q][victim_sel];
              state_q     <= S_WRITEBACK;
            end else if (!wr_q) begin
              mem_valid_q <= 1'b1;
              mem_write_q <= 1'b0;
              mem_addr_q  <= {tag_q, idx_q};
              state_q     <= S_REFILL;
            end else begin
              resp_rdata_q <= wdata_q;
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end
          end
        end
        S_WRITEBACK: begin
          if (bus.mem_ready) begin
            if (wr_q) begin
              mem_valid_q  <= 1'b0;
              resp_rdata_q <= wdata_q;
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end else begin
              mem_write_q <= 1'b0;
              mem_addr_q  <= {tag_q, idx_q};
              state_q     <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          if (bus.mem_ready) begin
            mem_valid_q  <= 1'b0;
            resp_rdata_q <= bus.mem_rdata;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE) && reset_n;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign hit_count      = hit_q;
  assign miss_count     = miss_q;

endmodule

// File: tb/tb_cache_assoc.sv
// Directed plus randomized bench for cache_assoc against a timestamp-LRU cache model.
module tb_cache_assoc;
  localparam int unsigned W = 2;
  localparam int unsigned S = 4;

  logic        clock;
  logic        reset_n;
  logic [15:0] hc, mc;

  cache_assoc_if #(.IDX_W(2), .TAG_W(8), .DATA_W(8)) bus ();

  cache_assoc #(.WAYS(W), .SETS(S), .TAG_W(8), .DATA_W(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .hit_count  (hc),
    .miss_count (mc)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  bit          m_valid [S][W];
  bit          m_dirty [S][W];
  logic [7:0]  m_tag   [S][W];
  logic [7:0]  m_data  [S][W];
  int unsigned m_use   [S][W];
  int unsigned tick;
  int unsigned m_hits, m_misses;

  logic [9:0]  obs_wb_addr, obs_rf_addr;
  logic [7:0]  obs_wb_data, obs_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int unsigned s = 0; s < S; s++) begin
      for (int unsigned w = 0; w < W; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = '0;
        m_data[s][w]  = '0;
        m_use[s][w]   = W - 1 - w;
      end
    end
    tick     = W;
    m_hits   = 0;
    m_misses = 0;
  endfunction

  function automatic int unsigned model_victim(input logic [1:0] idx);
    int unsigned v, best;
    for (int unsigned w = 0; w < W; w++) if (!m_valid[idx][w]) return w;
    v    = 0;
    best = m_use[idx][0];
    for (int unsigned w = 1; w < W; w++) begin
      if (m_use[idx][w] < best) begin
        best = m_use[idx][w];
        v    = w;
      end
    end
    return v;
  endfunction

  task automatic txn(input bit wr, input logic [1:0] idx, input logic [7:0] tag,
                     input logic [7:0] wd, input logic [7:0] rdv,
                     input int unsigned mdelay, input bit scramble, input bit hold);
    bit          hit, exp_wb, exp_rf, acc, done, is_wb;
    int unsigned way, vw, nph, p, wcnt, k, exp_lat;
    logic [7:0]  exp_rd, wb_data;
    logic [9:0]  wb_addr, rf_addr;

    hit = 1'b0;
    way = 0;
    for (int unsigned w = 0; w < W; w++) begin
      if (!hit && m_valid[idx][w] && m_tag[idx][w] == tag) begin
        hit = 1'b1;
        way = w;
      end
    end
    exp_wb  = 1'b0;
    exp_rf  = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    rf_addr = {tag, idx};
    if (hit) begin
      if (wr) begin
        m_data[idx][way]  = wd;
        m_dirty[idx][way] = 1'b1;
      end
      exp_rd = m_data[idx][way];
      if (m_hits < 65535) m_hits++;
      vw = way;
    end else begin
      if (m_misses < 65535) m_misses++;
      vw      = model_victim(idx);
      exp_wb  = m_valid[idx][vw] && m_dirty[idx][vw];
      wb_addr = {m_tag[idx][vw], idx};
      wb_data = m_data[idx][vw];
      exp_rf  = !wr;
      m_valid[idx][vw] = 1'b1;
      m_tag[idx][vw]   = tag;
      m_data[idx][vw]  = wr ? wd : rdv;
      m_dirty[idx][vw] = wr;
      exp_rd = m_data[idx][vw];
    end
    m_use[idx][vw] = tick;
    tick++;
    nph     = int'(exp_wb) + int'(exp_rf);
    exp_lat = 2 + nph * (1 + mdelay);

    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_index = idx;
    bus.req_tag   = tag;
    bus.req_wdata = wd;
    bus.mem_ready = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (bus.req_ready === 1'b1) acc = 1'b1;
      else @(negedge clock);
    end
    check("req_ready_idle", bus.req_ready, 1'b1);
    if (!acc) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clock);

    done = 1'b0;
    p    = 0;
    wcnt = 0;
    k    = 1;
    while (!done && k < 80) begin
      @(negedge clock);
      if (hold) check("no_reaccept", bus.req_ready, 1'b0);
      else bus.req_valid = 1'b0;
      if (scramble) begin
        bus.req_write = 1'($urandom);
        bus.req_index = 2'($urandom);
        bus.req_tag   = 8'($urandom);
        bus.req_wdata = 8'($urandom);
      end
      bus.mem_ready = 1'b0;
      if (bus.resp_valid === 1'b1) begin
        done      = 1'b1;
        obs_rdata = bus.resp_rdata;
        check("resp_hit", bus.resp_hit, hit);
        check("resp_rdata", bus.resp_rdata, exp_rd);
        check("latency", k, exp_lat);
        check("mem_phases", p, nph);
        check("mem_idle_at_resp", bus.mem_valid, 1'b0);
        check("hit_count", hc, m_hits);
        check("miss_count", mc, m_misses);
        bus.req_valid = 1'b0;
      end else if (bus.mem_valid === 1'b1) begin
        if (p >= nph) begin
          check("mem_unexpected", bus.mem_valid, 1'b0);
        end else begin
          is_wb = exp_wb && (p == 0);
          check("mem_write", bus.mem_write, is_wb);
          if (is_wb) begin
            obs_wb_addr = bus.mem_addr;
            obs_wb_data = bus.mem_wdata;
            check("wb_addr", bus.mem_addr, wb_addr);
            check("wb_data", bus.mem_wdata, wb_data);
          end else begin
            obs_rf_addr = bus.mem_addr;
            check("rf_addr", bus.mem_addr, rf_addr);
          end
          if (wcnt == mdelay) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = rdv;
            p++;
            wcnt = 0;
          end else begin
            bus.mem_rdata = 8'($urandom);
            wcnt++;
          end
        end
      end
      if (!done) begin
        @(posedge clock);
        k++;
      end
    end
    if (!done) check("resp_timeout", bus.resp_valid, 1'b1);
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    bit found;
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_index = '0;
    bus.req_tag   = '0;
    bus.req_wdata = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    obs_wb_addr   = '0;
    obs_rf_addr   = '0;
    obs_wb_data   = '0;
    obs_rdata     = '0;
    model_reset();

    #12;
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_resp_rdata", bus.resp_rdata, 8'h00);
    check("rst_mem_valid", bus.mem_valid, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 10'h000);
    check("rst_hit_count", hc, 16'd0);
    check("rst_miss_count", mc, 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("idle_req_ready", bus.req_ready, 1'b1);

    // Clean write miss, write hit, read hit.
    txn(1'b1, 2'd3, 8'h00, 8'h01, 8'h00, 0, 1'b0, 1'b0);
    txn(1'b1, 2'd3, 8'h00, 8'hFF, 8'h00, 0, 1'b0, 1'b0);
    txn(1'b0, 2'd3, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0);
    check("read_hit_data", obs_rdata, 8'hFF);
    check("hits_after_3", hc, 16'd2);
    check("misses_after_3", mc, 16'd1);

    // Stalled refill then repeat hit.
    txn(1'b0, 2'd2, 8'h07, 8'h00, 8'h5A, 3, 1'b0, 1'b0);
    check("refill_addr", obs_rf_addr, 10'h01E);
    check("refill_data", obs_rdata, 8'h5A);
    txn(1'b0, 2'd2, 8'h07, 8'h00, 8'h00, 0, 1'b0, 1'b0);

    // LRU victim with writeback.
    txn(1'b1, 2'd0, 8'h01, 8'h11, 8'h00, 0, 1'b0, 1'b0);
    txn(1'b1, 2'd0, 8'h02, 8'h22, 8'h00, 0, 1'b0, 1'b0);
    txn(1'b0, 2'd0, 8'h01, 8'h00, 8'h00, 0, 1'b0, 1'b0);
    txn(1'b1, 2'd0, 8'h03, 8'h33, 8'h00, 1, 1'b0, 1'b0);
    check("lru_wb_addr", obs_wb_addr, 10'h008);
    check("lru_wb_data", obs_wb_data, 8'h22);
    txn(1'b0, 2'd0, 8'h01, 8'h00, 8'h00, 0, 1'b0, 1'b0);
    check("lru_keep_01", obs_rdata, 8'h11);
    txn(1'b0, 2'd0, 8'h03, 8'h00, 8'h00, 0, 1'b0, 1'b0);
    check("lru_new_03", obs_rdata, 8'h33);

    // Fields scrambled and req_valid held through a stalled miss.
    txn(1'b0, 2'd1, 8'h33, 8'h00, 8'hC3, 2, 1'b1, 1'b1);
    txn(1'b1, 2'd0, 8'h02, 8'h44, 8'h00, 2, 1'b1, 1'b1);

    // Reset in the middle of a memory transaction.
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_index = 2'd1;
    bus.req_tag   = 8'h44;
    check("pre_rst_ready", bus.req_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.mem_valid === 1'b1) found = 1'b1;
      else @(negedge clock);
    end
    check("pre_rst_mem_valid", bus.mem_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_mem_valid", bus.mem_valid, 1'b0);
    check("midrst_req_ready", bus.req_ready, 1'b0);
    check("midrst_hit_count", hc, 16'd0);
    check("midrst_miss_count", mc, 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    txn(1'b0, 2'd3, 8'h00, 8'h00, 8'h9C, 1, 1'b0, 1'b0);

    // Randomized traffic over a small tag pool to force conflicts and writebacks.
    for (int n = 0; n < 60; n++) begin
      txn(1'($urandom), 2'($urandom), 8'($urandom_range(0, 3)), 8'($urandom),
          8'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_assoc.md
# cache_assoc

Parametrised N-way set-associative write-back cache, the successor of the fixed 2-way, 4-set, 8-bit L1 cache. Sits between the request driver (the `ram` test harness or a CPU front end) and a backing memory. Adds a valid/ready request handshake, a stalling memory port, true-LRU replacement for any way count, and hit/miss statistics. One request is in flight at a time.

## Interface
- WAYS, 2, associativity; power of two, ≥2.
- SETS, 4, number of sets; power of two, ≥2.
- TAG_W, 8, tag width.
- DATA_W, 8, line width; one word per line.
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  cache idle, can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_index  in  clog2(SETS)  set index.
- req_tag  in  TAG_W  tag.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle response strobe.
- resp_hit  out  1  request hit; valid with resp_valid.
- resp_rdata  out  DATA_W  read data; valid with resp_valid. Carries the written data on writes.
- mem_valid  out  1  memory request; held until accepted.
- mem_write  out  1  1 = writeback, 0 = refill read.
- mem_addr  out  TAG_W+clog2(SETS)  address {tag, index}.
- mem_wdata  out  DATA_W  writeback data.
- mem_ready  in  1  memory accepts or completes the request this cycle.
- mem_rdata  in  DATA_W  refill data; valid while mem_ready=1.
- hit_count  out  16  saturating hit counter.
- miss_count  out  16  saturating miss counter.

## Operation
- States: IDLE, LOOKUP, WRITEBACK, REFILL, RESP.
- IDLE: req_ready=1. A request is accepted when req_valid=1 and req_ready=1. All request fields are latched at acceptance; later input changes are ignored. Next state is LOOKUP.
- LOOKUP: all ways of the set are compared. A hit is valid=1 and a matching tag.
  - Read hit: rdata is taken from the matching way.
  - Write hit: data is written and dirty is set to 1.
  - After either hit: LRU is updated, hit_count increments, next state is RESP.
- LOOKUP miss: miss_count increments. The victim is the lowest-numbered invalid way, otherwise the LRU way. If the victim is valid and dirty, next state is WRITEBACK. Otherwise, a read goes to REFILL and a write installs directly (write-allocate, no fetch) and goes to RESP.
- WRITEBACK: mem_valid=1, mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim data. When mem_ready=1: a read goes to REFILL; a write installs and goes to RESP.
- REFILL: mem_valid=1, mem_write=0, mem_addr={req tag, index}. When mem_ready=1, mem_rdata is installed clean into the victim way and next state is RESP.
- Install: valid=1 and tag=req tag. For a write, data=wdata and dirty=1. For a read, data=mem_rdata and dirty=0. Every install also updates LRU.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- LRU: each way has a clog2(WAYS)-bit age per set. On access, the accessed way's age becomes 0 and every way with a smaller age increments by 1. The LRU way is the one with age WAYS-1.
- Counters saturate at 0xFFFF.

## Timing
- Reset values:
  - Outputs: req_ready=0 while reset_n=0, then 1 (IDLE). resp_valid, resp_hit, resp_rdata, mem_valid, mem_write, mem_addr, mem_wdata, hit_count and miss_count are all 0.
  - Cache state: all valid and dirty bits are 0; ages in each set are initialised to the way number.
- Hit latency: resp_valid rises 2 cycles after the accepting edge. req_ready is 1 again the cycle after resp_valid.
- Clean write miss: same latency as a hit.
- Memory phases: each adds 1 cycle plus the mem_ready wait. mem_valid and its fields are stable until mem_ready is sampled high.
- Reset mid-operation: asynchronous. Any memory transaction is aborted and mem_valid drops immediately. All lines are invalidated and dirty data is lost.
- req_valid during a non-IDLE state is ignored (req_ready=0).

## Structure
- Package `cache_pkg`: state enum, and helper functions for index width and way width (clog2).
- Sub-module `cache_lru`: per-set age update and victim select, parametrised by WAYS. Takes an access way and current ages; returns new ages and the LRU way.
- Storage arrays (data, tag, valid, dirty, age) are registers, so reset clears them.

## Test plan
Defaults apply (WAYS=2, SETS=4, TAG_W=8, DATA_W=8).
- Reset, then write idx 3 tag 0x00 data 0x01 -> resp_hit=0, no mem_valid, latency 2. Write 0xFF to the same address -> resp_hit=1, no mem traffic.
- Read idx 3 tag 0x00 -> resp_hit=1, resp_rdata=0xFF, resp_valid 2 cycles after acceptance. hit_count=2, miss_count=1.
- Read idx 2 tag 0x07, with mem_ready held low 3 cycles then high with mem_rdata=0x5A -> mem_addr=0x1E, mem_write=0, mem_valid stable while waiting; resp_rdata=0x5A, resp_hit=0. A repeat read hits.
- LRU writeback:
  - Stimulus: write idx 0 tag 0x01 data 0x11; write idx 0 tag 0x02 data 0x22; read tag 0x01; then write idx 0 tag 0x03 data 0x33.
  - Response: writeback with mem_addr=0x08, mem_wdata=0x22, then install. A later read of tag 0x01 hits 0x11 and a read of tag 0x03 hits 0x33.
- Reset mid-refill: drive reset_n=0 while mem_valid=1 -> mem_valid=0 immediately and counters read 0. A re-read of idx 3 tag 0x00 misses.
- Request fields changed after acceptance, and req_valid held high during a miss -> no second acceptance until IDLE, and the response matches the latched request.
